ctrl_pipe: RTL and testbench

CTRL_PIPE -- requirements
Module: ctrl_pipe

---
 rtl/ctrl_pkg.sv | 68 ++++++
 rtl/ctrl_decode.sv | 103 ++++++++++
 rtl/flopr.sv | 17 +
 rtl/floprc.sv | 18 +
 rtl/ctrl_pipe.sv | 145 ++++++++++++++
 tb/tb_ctrl_pipe.sv | 246 ++++++++++++++++++++++++
 6 files changed

// File: rtl/ctrl_pkg.sv
// Shared encodings for the ctrl_pipe control path: opcodes, functs, ALU codes,
// destination/result selectors, the decoded control bundle and the mult/div FSM states.
package ctrl_pkg;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_SLTI  = 6'h0A;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] FN_MFHI  = 6'h10;
    localparam logic [5:0] FN_MFLO  = 6'h12;
    localparam logic [5:0] FN_MULT  = 6'h18;
    localparam logic [5:0] FN_DIV   = 6'h1A;
    localparam logic [5:0] FN_ADD   = 6'h20;
    localparam logic [5:0] FN_SUB   = 6'h22;
    localparam logic [5:0] FN_AND   = 6'h24;
    localparam logic [5:0] FN_OR    = 6'h25;
    localparam logic [5:0] FN_SLT   = 6'h2A;

    localparam logic [2:0] ALU_ADD  = 3'd0;
    localparam logic [2:0] ALU_SUB  = 3'd1;
    localparam logic [2:0] ALU_AND  = 3'd2;
    localparam logic [2:0] ALU_OR   = 3'd3;
    localparam logic [2:0] ALU_SLT  = 3'd4;

    localparam logic [1:0] REGDST_RT  = 2'd0;
    localparam logic [1:0] REGDST_RD  = 2'd1;
    localparam logic [1:0] REGDST_R31 = 2'd2;

    localparam logic [1:0] RES_ALU  = 2'd0;
    localparam logic [1:0] RES_MEM  = 2'd1;
    localparam logic [1:0] RES_PC8  = 2'd2;
    localparam logic [1:0] RES_HILO = 2'd3;

    // Controls carried from D into E; an all-zero value is a bubble.
    typedef struct packed {
        logic       reg_write;
        logic       mem_write;
        logic       d_en;
        logic       alu_src;
        logic [1:0] reg_dst;
        logic [2:0] alu_ctl;
        logic [1:0] result_src;
        logic       md_start;
        logic       md_div;
    } dec_ctl_t;

    typedef enum logic {StIdle, StBusy} md_state_e;

    // ALU operation for the register-register ALU functs.
    function automatic logic [2:0] alu_of_funct(input logic [5:0] funct);
        case (funct)
            FN_SUB:  return ALU_SUB;
            FN_AND:  return ALU_AND;
            FN_OR:   return ALU_OR;
            FN_SLT:  return ALU_SLT;
            default: return ALU_ADD;
        endcase
    endfunction

endpackage

// File: rtl/ctrl_decode.sv
// Combinational decode of opcode/funct into pipeline controls and D-stage signals.
module ctrl_decode
    import ctrl_pkg::*;
(
    input  logic [5:0] op,
    input  logic [5:0] funct,
    output dec_ctl_t   ctl,
    output logic       branch,
    output logic       jump,
    output logic       ext_op,
    output logic       illegal,
    output logic       is_bne,
    output logic       md_use
);

    // Unknown encodings fall through to a bubble with illegal raised.
    always_comb begin
        ctl     = '0;
        branch  = 1'b0;
        jump    = 1'b0;
        ext_op  = 1'b1;
        illegal = 1'b0;
        is_bne  = 1'b0;
        md_use  = 1'b0;
        case (op)
            OP_RTYPE: begin
                case (funct)
                    FN_ADD, FN_SUB, FN_AND, FN_OR, FN_SLT: begin
                        ctl.reg_write = 1'b1;
                        ctl.reg_dst   = REGDST_RD;
                        ctl.alu_ctl   = alu_of_funct(funct);
                    end
                    FN_MULT: begin
                        ctl.md_start = 1'b1;
                        md_use       = 1'b1;
                    end
                    FN_DIV: begin
                        ctl.md_start = 1'b1;
                        ctl.md_div   = 1'b1;
                        md_use       = 1'b1;
                    end
                    FN_MFHI, FN_MFLO: begin
                        ctl.reg_write  = 1'b1;
                        ctl.reg_dst    = REGDST_RD;
                        ctl.result_src = RES_HILO;
                        md_use         = 1'b1;
                    end
                    default: illegal = 1'b1;
                endcase
            end
            OP_LW: begin
                ctl.reg_write  = 1'b1;
                ctl.alu_src    = 1'b1;
                ctl.d_en       = 1'b1;
                ctl.result_src = RES_MEM;
            end
            OP_SW: begin
                ctl.mem_write = 1'b1;
                ctl.alu_src   = 1'b1;
                ctl.d_en      = 1'b1;
            end
            OP_BEQ: begin
                branch      = 1'b1;
                ctl.alu_ctl = ALU_SUB;
            end
            OP_BNE: begin
                branch      = 1'b1;
                is_bne      = 1'b1;
                ctl.alu_ctl = ALU_SUB;
            end
            OP_ADDI: begin
                ctl.reg_write = 1'b1;
                ctl.alu_src   = 1'b1;
            end
            OP_SLTI: begin
                ctl.reg_write = 1'b1;
                ctl.alu_src   = 1'b1;
                ctl.alu_ctl   = ALU_SLT;
            end
            OP_ANDI: begin
                ctl.reg_write = 1'b1;
                ctl.alu_src   = 1'b1;
                ctl.alu_ctl   = ALU_AND;
                ext_op        = 1'b0;
            end
            OP_ORI: begin
                ctl.reg_write = 1'b1;
                ctl.alu_src   = 1'b1;
                ctl.alu_ctl   = ALU_OR;
                ext_op        = 1'b0;
            end
            OP_J: jump = 1'b1;
            OP_JAL: begin
                jump           = 1'b1;
                ctl.reg_write  = 1'b1;
                ctl.reg_dst    = REGDST_R31;
                ctl.result_src = RES_PC8;
            end
            default: illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/flopr.sv
// Plain register with synchronous active-high reset.
module flopr #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    // Load every cycle; reset clears.
    always_ff @(posedge clk) begin
        if (reset) q <= '0;
        else       q <= d;
    end

endmodule

// File: rtl/floprc.sv
// Register with synchronous active-high reset and synchronous clear.
module floprc #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    // Reset or clear loads zero, otherwise load d.
    always_ff @(posedge clk) begin
        if (reset || clear) q <= '0;
        else                q <= d;
    end

endmodule

// File: rtl/ctrl_pipe.sv
// Pipelined control unit: D decode, D->E->M->W control registers and a mult/div
// busy tracker that stalls dependent HI/LO users in D.
module ctrl_pipe
    import ctrl_pkg::*;
#(
    parameter int ALU_CTL_W = 4,
    parameter int MD_LAT    = 8
) (
    input  logic                 CLK,
    input  logic                 Reset,
    input  logic [5:0]           OpD,
    input  logic [5:0]           FunctD,
    input  logic                 FlushE,
    input  logic                 EqualD,
    output logic                 PCSrcD,
    output logic                 BranchD,
    output logic                 JumpD,
    output logic                 ExtOpD,
    output logic                 IllegalD,
    output logic                 StallMdD,
    output logic                 IEnF,
    output logic                 ALUSrcE,
    output logic [1:0]           RegDstE,
    output logic [ALU_CTL_W-1:0] ALUCtlE,
    output logic                 MdStartE,
    output logic                 MdDivE,
    output logic                 MemWriteM,
    output logic                 DEnM,
    output logic                 RegWriteE,
    output logic                 RegWriteM,
    output logic                 RegWriteW,
    output logic                 MdBusy,
    output logic                 MdDone,
    output logic [1:0]           ResultSrcE,
    output logic [1:0]           ResultSrcM,
    output logic [1:0]           ResultSrcW
);

    localparam int              CntW    = $clog2(MD_LAT + 1);
    localparam logic [CntW-1:0] CntLoad = CntW'(MD_LAT);
    localparam logic [CntW-1:0] CntOne  = CntW'(1);

    dec_ctl_t        ctl_d, ctl_e;
    logic            is_bne, md_use, bubble_e;
    logic [4:0]      m_d, m_q;
    logic [2:0]      w_d, w_q;
    logic [CntW-1:0] cnt_q, cnt_d;
    md_state_e       state_q, state_d;
    logic            done_q, done_d;

    ctrl_decode u_decode (
        .op      (OpD),
        .funct   (FunctD),
        .ctl     (ctl_d),
        .branch  (BranchD),
        .jump    (JumpD),
        .ext_op  (ExtOpD),
        .illegal (IllegalD),
        .is_bne  (is_bne),
        .md_use  (md_use)
    );

    assign PCSrcD   = BranchD & (is_bne ^ EqualD);
    // A mult/div in E counts as busy so back-to-back HI/LO users stall from the issue cycle.
    assign StallMdD = md_use & (MdBusy | MdStartE);
    assign IEnF     = ~(FlushE | StallMdD);
    assign bubble_e = FlushE | StallMdD;

    floprc #(.WIDTH($bits(dec_ctl_t))) u_reg_de (
        .clk   (CLK),
        .reset (Reset),
        .clear (bubble_e),
        .d     (ctl_d),
        .q     (ctl_e)
    );

    assign RegWriteE  = ctl_e.reg_write;
    assign ALUSrcE    = ctl_e.alu_src;
    assign RegDstE    = ctl_e.reg_dst;
    assign ALUCtlE    = ALU_CTL_W'(ctl_e.alu_ctl);
    assign ResultSrcE = ctl_e.result_src;
    assign MdStartE   = ctl_e.md_start;
    assign MdDivE     = ctl_e.md_div;

    assign m_d = {ctl_e.reg_write, ctl_e.mem_write, ctl_e.d_en, ctl_e.result_src};

    flopr #(.WIDTH(5)) u_reg_em (
        .clk   (CLK),
        .reset (Reset),
        .d     (m_d),
        .q     (m_q)
    );

    assign {RegWriteM, MemWriteM, DEnM, ResultSrcM} = m_q;
    assign w_d = {RegWriteM, ResultSrcM};

    flopr #(.WIDTH(3)) u_reg_mw (
        .clk   (CLK),
        .reset (Reset),
        .d     (w_d),
        .q     (w_q)
    );

    assign {RegWriteW, ResultSrcW} = w_q;

    // Busy counter: reload on issue, otherwise count down to zero.
    always_comb begin
        cnt_d = cnt_q;
        if (MdStartE)           cnt_d = CntLoad;
        else if (cnt_q != '0)   cnt_d = cnt_q - CntOne;
    end

    // FSM next state; completion is flagged on the 1->0 counter step.
    always_comb begin
        state_d = state_q;
        done_d  = 1'b0;
        case (state_q)
            StIdle: if (MdStartE) state_d = StBusy;
            StBusy: begin
                if (!MdStartE && cnt_q == CntOne) begin
                    state_d = StIdle;
                    done_d  = 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Counter, FSM and done flag; reset aborts any operation without a done pulse.
    always_ff @(posedge CLK) begin
        if (Reset) begin
            cnt_q   <= '0;
            state_q <= StIdle;
            done_q  <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            state_q <= state_d;
            done_q  <= done_d;
        end
    end

    assign MdBusy = (cnt_q != '0);
    assign MdDone = done_q;

endmodule

// File: tb/tb_ctrl_pipe.sv
// Scoreboard bench for ctrl_pipe: directed instructions push expected values keyed by
// cycle; a negedge monitor compares them. Instance 0 uses MD_LAT=8, instance 1 MD_LAT=1.
module tb_ctrl_pipe;
    import ctrl_pkg::*;

    localparam int AW = 4;

    localparam int S_PCSRC = 0,  S_BRANCH = 1,  S_JUMP = 2,    S_EXTOP = 3,   S_ILL = 4;
    localparam int S_STALL = 5,  S_IENF = 6,    S_ALUSRC = 7,  S_RDSTE = 8,   S_ALUCTL = 9;
    localparam int S_MDST = 10,  S_MDDIV = 11,  S_MEMWR = 12,  S_DEN = 13,    S_RWE = 14;
    localparam int S_RWM = 15,   S_RWW = 16,    S_BUSY = 17,   S_DONE = 18,   S_RSE = 19;
    localparam int S_RSM = 20,   S_RSW = 21;

    logic       clk = 1'b0;
    logic       Reset;
    logic [5:0] OpD, FunctD;
    logic       FlushE, EqualD;

    logic          pcsrc[2], branch[2], jump[2], extop[2], ill[2], stall[2], ienf[2];
    logic          alusrc[2], mdst[2], mddiv[2], memwr[2], den[2];
    logic          rwe[2], rwm[2], rww[2], busy[2], done[2];
    logic [1:0]    rdste[2], rse[2], rsm[2], rsw[2];
    logic [AW-1:0] aluctl[2];

    typedef struct {
        int         cyc;
        int         dut;
        int         sig;
        logic [7:0] val;
    } exp_t;

    exp_t sb[$];
    int   cyc     = 0;
    int   n_tests = 0;
    int   n_fail  = 0;

    always #5 clk = ~clk;

    ctrl_pipe #(.ALU_CTL_W(AW), .MD_LAT(8)) u_dut (
        .CLK(clk), .Reset(Reset), .OpD(OpD), .FunctD(FunctD), .FlushE(FlushE), .EqualD(EqualD),
        .PCSrcD(pcsrc[0]), .BranchD(branch[0]), .JumpD(jump[0]), .ExtOpD(extop[0]),
        .IllegalD(ill[0]), .StallMdD(stall[0]), .IEnF(ienf[0]), .ALUSrcE(alusrc[0]),
        .RegDstE(rdste[0]), .ALUCtlE(aluctl[0]), .MdStartE(mdst[0]), .MdDivE(mddiv[0]),
        .MemWriteM(memwr[0]), .DEnM(den[0]), .RegWriteE(rwe[0]), .RegWriteM(rwm[0]),
        .RegWriteW(rww[0]), .MdBusy(busy[0]), .MdDone(done[0]), .ResultSrcE(rse[0]),
        .ResultSrcM(rsm[0]), .ResultSrcW(rsw[0])
    );

    ctrl_pipe #(.ALU_CTL_W(AW), .MD_LAT(1)) u_dut1 (
        .CLK(clk), .Reset(Reset), .OpD(OpD), .FunctD(FunctD), .FlushE(FlushE), .EqualD(EqualD),
        .PCSrcD(pcsrc[1]), .BranchD(branch[1]), .JumpD(jump[1]), .ExtOpD(extop[1]),
        .IllegalD(ill[1]), .StallMdD(stall[1]), .IEnF(ienf[1]), .ALUSrcE(alusrc[1]),
        .RegDstE(rdste[1]), .ALUCtlE(aluctl[1]), .MdStartE(mdst[1]), .MdDivE(mddiv[1]),
        .MemWriteM(memwr[1]), .DEnM(den[1]), .RegWriteE(rwe[1]), .RegWriteM(rwm[1]),
        .RegWriteW(rww[1]), .MdBusy(busy[1]), .MdDone(done[1]), .ResultSrcE(rse[1]),
        .ResultSrcM(rsm[1]), .ResultSrcW(rsw[1])
    );

    function automatic logic [7:0] get(input int d, input int s);
        case (s)
            S_PCSRC:  return 8'(pcsrc[d]);
            S_BRANCH: return 8'(branch[d]);
            S_JUMP:   return 8'(jump[d]);
            S_EXTOP:  return 8'(extop[d]);
            S_ILL:    return 8'(ill[d]);
            S_STALL:  return 8'(stall[d]);
            S_IENF:   return 8'(ienf[d]);
            S_ALUSRC: return 8'(alusrc[d]);
            S_RDSTE:  return 8'(rdste[d]);
            S_ALUCTL: return 8'(aluctl[d]);
            S_MDST:   return 8'(mdst[d]);
            S_MDDIV:  return 8'(mddiv[d]);
            S_MEMWR:  return 8'(memwr[d]);
            S_DEN:    return 8'(den[d]);
            S_RWE:    return 8'(rwe[d]);
            S_RWM:    return 8'(rwm[d]);
            S_RWW:    return 8'(rww[d]);
            S_BUSY:   return 8'(busy[d]);
            S_DONE:   return 8'(done[d]);
            S_RSE:    return 8'(rse[d]);
            S_RSM:    return 8'(rsm[d]);
            default:  return 8'(rsw[d]);
        endcase
    endfunction

    function automatic string sname(input int s);
        case (s)
            S_PCSRC:  return "PCSrcD";    S_BRANCH: return "BranchD";  S_JUMP:  return "JumpD";
            S_EXTOP:  return "ExtOpD";    S_ILL:    return "IllegalD"; S_STALL: return "StallMdD";
            S_IENF:   return "IEnF";      S_ALUSRC: return "ALUSrcE";  S_RDSTE: return "RegDstE";
            S_ALUCTL: return "ALUCtlE";   S_MDST:   return "MdStartE"; S_MDDIV: return "MdDivE";
            S_MEMWR:  return "MemWriteM"; S_DEN:    return "DEnM";     S_RWE:   return "RegWriteE";
            S_RWM:    return "RegWriteM"; S_RWW:    return "RegWriteW"; S_BUSY: return "MdBusy";
            S_DONE:   return "MdDone";    S_RSE:    return "ResultSrcE"; S_RSM: return "ResultSrcM";
            default:  return "ResultSrcW";
        endcase
    endfunction

    task automatic push(input int at, input int s, input logic [7:0] v);
        sb.push_back('{at, 0, s, v});
    endtask

    task automatic push1(input int at, input int s, input logic [7:0] v);
        sb.push_back('{at, 1, s, v});
    endtask

    // Advance one cycle and present a new D-stage instruction.
    task automatic step(input logic [5:0] op, input logic [5:0] fn, input logic eq,
                        input logic fl, input logic rst);
        @(posedge clk);
        #1;
        cyc++;
        OpD    = op;
        FunctD = fn;
        EqualD = eq;
        FlushE = fl;
        Reset  = rst;
    endtask

    // Monitor: compare every expectation due in the current cycle.
    always @(negedge clk) begin
        for (int i = sb.size() - 1; i >= 0; i--) begin
            if (sb[i].cyc == cyc) begin
                logic [7:0] got;
                got = get(sb[i].dut, sb[i].sig);
                n_tests++;
                if (got !== sb[i].val) begin
                    n_fail++;
                    $display("FAIL %s dut%0d cyc=%0d got=%0d want=%0d", sname(sb[i].sig),
                             sb[i].dut, cyc, got, sb[i].val);
                end
                sb.delete(i);
            end
        end
    end

    initial begin
        int c, m, d;
        Reset  = 1'b1;
        OpD    = OP_BNE;
        FunctD = 6'h00;
        EqualD = 1'b0;
        FlushE = 1'b0;

        // Reset: registered outputs zero, decode still follows OpD.
        step(OP_BNE, 6'h00, 1'b0, 1'b0, 1'b1); c = cyc;
        push(c, S_PCSRC, 1); push(c, S_BRANCH, 1); push(c, S_RWE, 0); push(c, S_RWW, 0);
        push(c, S_BUSY, 0); push(c, S_DONE, 0); push(c, S_MDST, 0);
        step(OP_BEQ, 6'h00, 1'b0, 1'b0, 1'b1); c = cyc;
        push(c, S_PCSRC, 0); push(c, S_BRANCH, 1); push(c, S_RSW, 0); push(c, S_RWM, 0);

        // add
        step(OP_RTYPE, FN_ADD, 1'b0, 1'b0, 1'b0); c = cyc;
        push(c, S_ILL, 0); push(c, S_STALL, 0); push(c, S_IENF, 1); push(c, S_EXTOP, 1);
        push(c + 1, S_RWE, 1); push(c + 1, S_RDSTE, 1); push(c + 1, S_ALUCTL, 0);
        push(c + 1, S_ALUSRC, 0); push(c + 2, S_RWM, 1); push(c + 2, S_DEN, 0);
        push(c + 3, S_RWW, 1); push(c + 3, S_RSW, 0);
        // branches
        step(OP_BNE, 6'h00, 1'b0, 1'b0, 1'b0); c = cyc;
        push(c, S_PCSRC, 1); push(c + 1, S_RWE, 0); push(c + 1, S_ALUCTL, 1);
        step(OP_BEQ, 6'h00, 1'b0, 1'b0, 1'b0); push(cyc, S_PCSRC, 0);
        step(OP_BEQ, 6'h00, 1'b1, 1'b0, 1'b0); push(cyc, S_PCSRC, 1);
        step(OP_BNE, 6'h00, 1'b1, 1'b0, 1'b0); push(cyc, S_PCSRC, 0);
        // lw / sw
        step(OP_LW, 6'h00, 1'b0, 1'b0, 1'b0); c = cyc;
        push(c + 1, S_ALUSRC, 1); push(c + 1, S_RDSTE, 0); push(c + 1, S_RSE, 1);
        push(c + 2, S_DEN, 1); push(c + 2, S_MEMWR, 0); push(c + 2, S_RSM, 1);
        push(c + 3, S_RSW, 1); push(c + 3, S_RWW, 1);
        step(OP_SW, 6'h00, 1'b0, 1'b0, 1'b0); c = cyc;
        push(c + 1, S_RWE, 0); push(c + 1, S_ALUSRC, 1);
        push(c + 2, S_MEMWR, 1); push(c + 2, S_DEN, 1); push(c + 2, S_RWM, 0);
        // immediates and R-type ALU ops
        step(OP_ANDI, 6'h00, 1'b0, 1'b0, 1'b0); push(cyc, S_EXTOP, 0); push(cyc + 1, S_ALUCTL, 2);
        step(OP_ORI, 6'h00, 1'b0, 1'b0, 1'b0);  push(cyc, S_EXTOP, 0); push(cyc + 1, S_ALUCTL, 3);
        step(OP_SLTI, 6'h00, 1'b0, 1'b0, 1'b0); push(cyc, S_EXTOP, 1); push(cyc + 1, S_ALUCTL, 4);
        step(OP_RTYPE, FN_SUB, 1'b0, 1'b0, 1'b0); push(cyc + 1, S_ALUCTL, 1);
        step(OP_RTYPE, FN_OR, 1'b0, 1'b0, 1'b0);  push(cyc + 1, S_ALUCTL, 3);
        step(OP_RTYPE, FN_SLT, 1'b0, 1'b0, 1'b0); push(cyc + 1, S_ALUCTL, 4);
        push(cyc + 1, S_RDSTE, 1);
        // flushed addi
        step(OP_ADDI, 6'h00, 1'b0, 1'b1, 1'b0); c = cyc;
        push(c, S_IENF, 0); push(c, S_STALL, 0); push(c + 1, S_RWE, 0); push(c + 1, S_ALUSRC, 0);
        push(c + 2, S_RWM, 0);
        // illegal encodings
        step(6'h3F, 6'h00, 1'b0, 1'b0, 1'b0); c = cyc;
        push(c, S_ILL, 1); push(c + 1, S_RWE, 0); push(c + 1, S_ALUSRC, 0);
        push(c + 1, S_ALUCTL, 0); push(c + 1, S_RSE, 0); push(c + 1, S_RDSTE, 0);
        push(c + 2, S_MEMWR, 0); push(c + 2, S_DEN, 0);
        step(OP_RTYPE, 6'h3F, 1'b0, 1'b0, 1'b0); c = cyc;
        push(c, S_ILL, 1); push(c + 1, S_RWE, 0); push(c + 1, S_RDSTE, 0);
        // jal / j
        step(OP_JAL, 6'h00, 1'b0, 1'b0, 1'b0); c = cyc;
        push(c, S_JUMP, 1); push(c, S_BRANCH, 0); push(c, S_PCSRC, 0);
        push(c + 1, S_RDSTE, 2); push(c + 1, S_RWE, 1); push(c + 1, S_RSE, 2);
        push(c + 3, S_RSW, 2); push(c + 3, S_RWW, 1);
        step(OP_J, 6'h00, 1'b0, 1'b0, 1'b0); push(cyc, S_JUMP, 1); push(cyc + 1, S_RWE, 0);

        // mult followed by a stalled mflo; one stalled cycle also carries a flush.
        step(OP_RTYPE, FN_MULT, 1'b0, 1'b0, 1'b0); m = cyc;
        push(m, S_STALL, 0);
        push(m + 1, S_MDST, 1); push(m + 1, S_MDDIV, 0); push(m + 1, S_RWE, 0);
        push(m + 1, S_BUSY, 0); push(m + 2, S_MDST, 0);
        for (int k = 1; k <= 9; k++) begin
            push(m + k, S_STALL, 1); push(m + k, S_IENF, 0);
        end
        push(m + 10, S_STALL, 0); push(m + 10, S_IENF, 1);
        push(m + 2, S_BUSY, 1); push(m + 5, S_BUSY, 1); push(m + 9, S_BUSY, 1);
        push(m + 10, S_BUSY, 0);
        push(m + 9, S_DONE, 0); push(m + 10, S_DONE, 1); push(m + 11, S_DONE, 0);
        push(m + 11, S_RSE, 3); push(m + 11, S_RDSTE, 1); push(m + 11, S_RWE, 1);
        push1(m + 1, S_STALL, 1); push1(m + 2, S_STALL, 1); push1(m + 3, S_STALL, 0);
        push1(m + 1, S_BUSY, 0);  push1(m + 2, S_BUSY, 1);  push1(m + 3, S_BUSY, 0);
        push1(m + 2, S_DONE, 0);  push1(m + 3, S_DONE, 1);  push1(m + 4, S_DONE, 0);
        for (int k = 1; k <= 10; k++) begin
            step(OP_RTYPE, FN_MFLO, 1'b0, (k == 4), 1'b0);
        end

        // div aborted by reset when the counter reads 4.
        step(OP_RTYPE, FN_DIV, 1'b0, 1'b0, 1'b0); d = cyc;
        push(d, S_STALL, 0); push(d + 1, S_MDST, 1); push(d + 1, S_MDDIV, 1);
        push(d + 6, S_BUSY, 1);
        push(d + 7, S_BUSY, 0); push(d + 7, S_RWE, 0); push(d + 7, S_RWM, 0);
        push(d + 7, S_RWW, 0); push(d + 7, S_MDST, 0); push(d + 7, S_RSW, 0);
        push(d + 7, S_RDSTE, 0); push(d + 7, S_ALUCTL, 0);
        push(d + 8, S_RWE, 1); push(d + 8, S_RWM, 0); push(d + 8, S_RWW, 0);
        push(d + 10, S_RWW, 1);
        for (int k = 7; k <= 12; k++) begin
            push(d + k, S_DONE, 0); push(d + k, S_BUSY, 0);
        end
        for (int k = 1; k <= 12; k++) begin
            step(OP_RTYPE, FN_ADD, 1'b0, 1'b0, (k == 6));
        end
        step(OP_RTYPE, FN_ADD, 1'b0, 1'b0, 1'b0);

        @(negedge clk);
        #1;
        if (sb.size() != 0) begin
            n_tests += sb.size();
            n_fail  += sb.size();
            $display("FAIL scoreboard_leftover got=%0d want=0", sb.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
